// File: rtl/btn_rst_debounce.sv
// rtl/btn_rst_debounce.sv - debounced, stretched reset request from the active-low board button
// Optional press counter: BTN_RST_DEBOUNCE_PRESS_CNT_EN
module btn_rst_debounce #(
    parameter int DebounceCycles = 250000,
    parameter int MinPulseCycles = 1024,
    parameter int SyncStages     = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_ni,
    output logic       rst_btn_o,
    output logic       btn_level_o,
    output logic [7:0] press_cnt_o
);

    localparam int MaxCycles = (DebounceCycles > MinPulseCycles) ? DebounceCycles : MinPulseCycles;
    localparam int CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] DebLast   = CntW'(DebounceCycles - 1);
    localparam logic [CntW-1:0] PulseLast = CntW'(MinPulseCycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_CHK,
        ASSERT,
        HOLD,
        RELEASE_CHK
    } state_t;

    state_t                r_state;
    logic [CntW-1:0]       r_cnt;
    logic [SyncStages-1:0] r_sync;
    logic                  r_rst_btn;
    logic                  r_level;
    logic                  w_pressed;
    logic                  w_accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], ~btn_ni};
        end
    end

    assign w_pressed = r_sync[SyncStages-1];
    assign w_accept  = (r_state == PRESS_CHK) && w_pressed && (r_cnt == DebLast);

    // Counter is shared by both debounce checks and the stretch; it restarts on every state entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rst_btn <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rst_btn <= 1'b0;
                    r_level   <= 1'b0;
                    if (w_pressed) begin
                        r_state <= PRESS_CHK;
                        r_cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!w_pressed) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DebLast) begin
                        r_state   <= ASSERT;
                        r_cnt     <= '0;
                        r_rst_btn <= 1'b1;
                        r_level   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                ASSERT: begin
                    r_rst_btn <= 1'b1;
                    if (r_cnt == PulseLast) begin
                        r_state <= w_pressed ? HOLD : RELEASE_CHK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                HOLD: begin
                    r_rst_btn <= 1'b1;
                    if (!w_pressed) begin
                        r_state <= RELEASE_CHK;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_CHK: begin
                    if (w_pressed) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end else if (r_cnt == DebLast) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_rst_btn <= 1'b0;
                        r_level   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    r_rst_btn <= 1'b0;
                    r_level   <= 1'b0;
                end
            endcase
        end
    end

    assign rst_btn_o   = r_rst_btn;
    assign btn_level_o = r_level;

`ifdef BTN_RST_DEBOUNCE_PRESS_CNT_EN
    logic [7:0] r_press_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_press_cnt <= 8'd0;
        end else if (w_accept) begin
            r_press_cnt <= r_press_cnt + 8'd1;
        end
    end

    assign press_cnt_o = r_press_cnt;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
    assign press_cnt_o     = 8'd0;
`endif

endmodule
